// File: rtl/split_trk_pkg.sv
// Shared definitions for the split_trk transaction-tracking splitter:
// request/response widths, field positions inside a bus slice, FSM state
// encodings and the default error read data.
package split_trk_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DERR = 2'd2;
  localparam logic [1:0] ST_TOUT = 2'd3;

  // Read data returned to the master on a decode error or a timeout abort
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  // Response slice layout {rdata, ready}
  localparam int RESP_READY_POS = 0;
  localparam int RESP_RDATA_LSB = 1;

  // Request slice width: {valid, addr, wdata, wstrb}
  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Response slice width: {rdata, ready}
  function automatic int resp_w(input int data_w);
    return data_w + 1;
  endfunction

  // Position of the valid bit inside a request slice
  function automatic int req_valid_pos(input int addr_w, input int data_w);
    return req_w(addr_w, data_w) - 1;
  endfunction

  // LSB of the address field inside a request slice
  function automatic int req_addr_lsb(input int data_w);
    return data_w + data_w / 8;
  endfunction

  // LSB of slave i's request slice in the flattened s_req bus
  function automatic int req_slice_lsb(input int i, input int addr_w, input int data_w);
    return i * req_w(addr_w, data_w);
  endfunction

  // LSB of slave i's response slice in the flattened s_resp bus
  function automatic int resp_slice_lsb(input int i, input int data_w);
    return i * resp_w(data_w);
  endfunction

endpackage

// File: rtl/split_trk_dec.sv
// Slave-select decoder: pulls the select field out of the address and
// flags whether it names an existing slave (N_SLAVES need not be a power
// of two). Purely combinational; shared with the multi-master crossbar.
module split_trk_dec
  import split_trk_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W   = 32,
  parameter int P_SLAVES = ADDR_W - 1,
  localparam int NB      = $clog2(N_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NB-1:0]     sel,
  output logic              hit
);

  // One extra bit so the slave count itself is representable
  localparam logic [NB:0] N_LIM = (NB + 1)'(N_SLAVES);

  // Only the select field matters; the rest of the address is don't-care here
  logic unused_addr;
  assign unused_addr = ^addr;

  assign sel = addr[P_SLAVES -: NB];
  assign hit = ({1'b0, sel} < N_LIM);

endmodule

// File: rtl/split_trk.sv
// Address-decoded 1-to-N splitter with transaction tracking. The slave
// selected at the start of a transaction is latched so the response path
// follows the registered select, not the live address. Unmapped selects
// get a one-cycle error response.
// Optional: define SPLIT_TIMEOUT_EN to abort transactions whose slave
// stays not-ready for TIMEOUT busy cycles.
module split_trk
  import split_trk_pkg::*;
#(
  parameter int              N_SLAVES = 2,
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              P_SLAVES = ADDR_W - 1,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA),
  parameter int              TIMEOUT  = 256,
  localparam int             REQ_W    = req_w(ADDR_W, DATA_W),
  localparam int             RESP_W   = resp_w(DATA_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_W-1:0]           m_req,
  output logic [RESP_W-1:0]          m_resp,
  output logic [N_SLAVES*REQ_W-1:0]  s_req,
  input  logic [N_SLAVES*RESP_W-1:0] s_resp,
  input  logic                       err_clr,
  output logic [1:0]                 err
);

  localparam int NB        = $clog2(N_SLAVES);
  localparam int VALID_POS = req_valid_pos(ADDR_W, DATA_W);
  localparam int ADDR_LSB  = req_addr_lsb(DATA_W);

  logic [1:0]        state_q, state_d;
  logic [NB-1:0]     sel_q, sel_d, route_sel;
  logic              hit, route_en, req_valid, resp_ready;
  logic [RESP_W-1:0] route_resp;
  logic              dec_err_set, to_hit;
  logic              err_dec_q, err_to;

  split_trk_dec #(
    .N_SLAVES (N_SLAVES),
    .ADDR_W   (ADDR_W),
    .P_SLAVES (P_SLAVES)
  ) u_dec (
    .addr (m_req[ADDR_LSB +: ADDR_W]),
    .sel  (sel_d),
    .hit  (hit)
  );

  assign req_valid  = m_req[VALID_POS];
  assign resp_ready = route_resp[RESP_READY_POS];

  // Pick the routing target: live decode while idle, latched select while busy
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    route_en  = 1'b0;
    route_sel = sel_d;
    case (state_q)
      ST_IDLE: route_en = req_valid && hit;
      ST_BUSY: begin
        route_en  = 1'b1;
        route_sel = sel_q;
      end
      default: ;
    endcase
  end

  // Request demux to the chosen slave and response mux back from it only
  always_comb begin
    s_req      = '0;
    route_resp = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (route_en && (route_sel == NB'(i))) begin
        s_req[req_slice_lsb(i, ADDR_W, DATA_W) +: REQ_W] = m_req;
        route_resp = s_resp[resp_slice_lsb(i, DATA_W) +: RESP_W];
      end
    end
  end

`ifdef SPLIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic             err_to_q;

  // A ready in the last allowed cycle still completes normally
  assign to_hit = (state_q == ST_BUSY) && !resp_ready && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Count busy cycles spent waiting for the slave
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      cnt_q <= '0;
    end else if ((state_q == ST_BUSY) && !resp_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Sticky timeout flag; a new abort beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_to_q <= 1'b0;
    end else begin
      err_to_q <= to_hit | (err_to_q & ~err_clr);
    end
  end

  assign err_to = err_to_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign to_hit         = 1'b0;
  assign err_to         = 1'b0;
`endif

  // Next-state logic and decode-error detection
  always_comb begin
    state_d     = state_q;
    dec_err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!hit) begin
            state_d     = ST_DERR;
            dec_err_set = 1'b1;
          end else if (!resp_ready) begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else if (to_hit) begin
          state_d = ST_TOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Master response: error word in the abort states, routed slave otherwise
  always_comb begin
    case (state_q)
      ST_DERR, ST_TOUT: m_resp = {ERR_DATA, 1'b1};
      default:          m_resp = route_resp;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the slave select when a transaction goes multi-cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
    end else if ((state_q == ST_IDLE) && req_valid && hit && !resp_ready) begin
      sel_q <= sel_d;
    end
  end

  // Sticky decode-error flag; a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_dec_q <= 1'b0;
    end else begin
      err_dec_q <= dec_err_set | (err_dec_q & ~err_clr);
    end
  end

  assign err = {err_to, err_dec_q};

endmodule

// File: tb/tb_split_trk.sv
// Self-checking bench for split_trk (N_SLAVES=3, select=addr[31:30],
// TIMEOUT=8). Works with or without SPLIT_TIMEOUT_EN defined.
module tb_split_trk;

  localparam int N       = 3;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;
  localparam int REQ_W   = 1 + AW + DW + DW / 8;
  localparam int RESP_W  = DW + 1;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
`ifdef SPLIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [REQ_W-1:0]      m_req;
  logic [RESP_W-1:0]     m_resp;
  logic [N*REQ_W-1:0]    s_req;
  logic [N*RESP_W-1:0]   s_resp;
  logic                  err_clr;
  logic [1:0]            err;

  int       errors  = 0;
  int       checks  = 0;
  logic [1:0] exp_err = 2'b00;
  bit       rand_clr = 1'b0;

  always #5 clk = ~clk;

  split_trk #(
    .N_SLAVES (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .P_SLAVES (31),
    .ERR_DATA (32'hDEAD_BEEF),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_resp  (m_resp),
    .s_req   (s_req),
    .s_resp  (s_resp),
    .err_clr (err_clr),
    .err     (err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk_req(input logic valid, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [3:0] wstrb);
    return {valid, addr, wdata, wstrb};
  endfunction

  // Target slave gets tgt_resp; every other slave drives random noise
  task automatic drive_slaves(input int tgt, input logic [RESP_W-1:0] tgt_resp);
    for (int j = 0; j < N; j++) begin
      if (j == tgt) s_resp[j*RESP_W +: RESP_W] = tgt_resp;
      else          s_resp[j*RESP_W +: RESP_W] = {$urandom, 1'($urandom)};
    end
  endtask

  // Only slave tgt may see the request (tgt<0: nobody)
  task automatic check_outputs(input string tag, input int tgt, input logic [REQ_W-1:0] req,
                               input logic [RESP_W-1:0] exp_resp);
    for (int j = 0; j < N; j++)
      check($sformatf("%s s_req[%0d]", tag, j), s_req[j*REQ_W +: REQ_W], (j == tgt) ? req : '0);
    check({tag, " m_resp"}, m_resp, exp_resp);
    check({tag, " err"}, err, exp_err);
  endtask

  // Advance the sticky-flag model across the clock edge, then move to the next cycle
  task automatic finish_cycle(input logic [1:0] set);
    exp_err = (err_clr ? 2'b00 : exp_err) | set;
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_clr(input bit force_clr);
    return force_clr || (rand_clr && ($urandom_range(0, 7) == 0));
  endfunction

  task automatic idle_cycles(input int n, input bit force_clr);
    for (int k = 0; k < n; k++) begin
      m_req   = mk_req(1'b0, $urandom, $urandom, 4'($urandom));
      err_clr = pick_clr(force_clr);
      drive_slaves(-1, '0);
      @(negedge clk);
      check_outputs("idle", -1, '0, '0);
      finish_cycle(2'b00);
    end
  endtask

  // One master transaction. lat = cycle (0 = request cycle) in which the
  // addressed slave raises ready; toggle flips addr[31:30] to 2'b10 while waiting.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int lat, input bit toggle, input logic [31:0] rdata, input bit clr0);
    int t;
    int done_c;
    bit abort;
    logic [31:0] a;
    logic [RESP_W-1:0] tresp;
    logic [1:0] set;
    t = int'(addr[31:30]);
    if (t >= N) begin
      m_req   = mk_req(1'b1, addr, wdata, wstrb);
      err_clr = pick_clr(clr0);
      drive_slaves(-1, '0);
      @(negedge clk);
      check_outputs("derr req", -1, '0, '0);
      finish_cycle(2'b01);
      err_clr = pick_clr(1'b0);
      drive_slaves(-1, '0);
      @(negedge clk);
      check_outputs("derr resp", -1, '0, {ERR_DATA, 1'b1});
      finish_cycle(2'b00);
      return;
    end
    abort  = TO_EN && (lat > TIMEOUT);
    done_c = abort ? TIMEOUT + 1 : lat;
    for (int c = 0; c <= done_c; c++) begin
      a = addr;
      if (toggle && c > 0) a[31:30] = 2'b10;
      m_req   = mk_req(1'b1, a, wdata, wstrb);
      err_clr = pick_clr(clr0 && c == 0);
      set     = 2'b00;
      if (abort && c == done_c) begin
        drive_slaves(-1, '0);
        @(negedge clk);
        check_outputs("tout", -1, '0, {ERR_DATA, 1'b1});
      end else begin
        tresp = (c == lat) ? {rdata, 1'b1} : {32'($urandom), 1'b0};
        drive_slaves(t, tresp);
        @(negedge clk);
        check_outputs((c == lat) ? "txn done" : "txn wait", t, m_req, tresp);
        if (abort && c == TIMEOUT) set = 2'b10;
      end
      finish_cycle(set);
    end
  endtask

  initial begin
    int sel;
    rst     = 1'b1;
    m_req   = '0;
    err_clr = 1'b0;
    drive_slaves(-1, '0);
    #12;
    check_outputs("reset", -1, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero-latency read from slave 1
    run_txn(32'h4000_0010, $urandom, 4'h0, 0, 1'b0, 32'h1234_5678, 1'b0);
    idle_cycles(1, 1'b0);
    // Multi-cycle write to slave 0 with the address changing mid-wait
    run_txn(32'h0000_0004, 32'hA5A5_A5A5, 4'hF, 3, 1'b1, $urandom, 1'b0);
    // Unmapped select, then clear the flag
    run_txn(32'hC000_0000, $urandom, 4'hF, 0, 1'b0, '0, 1'b0);
    idle_cycles(1, 1'b1);
    idle_cycles(1, 1'b0);
    // Hung slave 2, then slave 2 ready in the last allowed busy cycle
    run_txn(32'h8000_0000, $urandom, 4'h0, 50, 1'b0, 32'h0BAD_0BAD, 1'b0);
    idle_cycles(1, 1'b1);
    run_txn(32'h8000_0000, $urandom, 4'h0, TIMEOUT, 1'b0, 32'hCAFE_F00D, 1'b0);
    idle_cycles(1, 1'b0);
    // New decode error in the same cycle as a clear: the set wins
    run_txn(32'hC000_0000, $urandom, 4'h0, 0, 1'b0, '0, 1'b0);
    run_txn(32'hC000_0004, $urandom, 4'h0, 0, 1'b0, '0, 1'b1);
    idle_cycles(1, 1'b0);

    // Asynchronous reset in the middle of a busy transaction to slave 1
    m_req   = mk_req(1'b1, 32'h4000_0020, $urandom, 4'hF);
    err_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_slaves(1, {32'($urandom), 1'b0});
      @(posedge clk);
      #1;
    end
    #2;
    rst     = 1'b1;
    m_req   = '0;
    exp_err = 2'b00;
    #1;
    check_outputs("rst mid-busy", -1, '0, '0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle_cycles(1, 1'b0);
    run_txn(32'h4000_0040, $urandom, 4'h3, 1, 1'b0, 32'h5555_AAAA, 1'b0);

    // Randomized traffic against the transaction-level model
    rand_clr = 1'b1;
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 3);
      run_txn({2'(sel), 30'($urandom)}, $urandom, 4'($urandom), $urandom_range(0, 12),
              1'($urandom), $urandom, 1'b0);
      idle_cycles($urandom_range(0, 2), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
